// File: rtl/spi_master_cfg.sv
// SPI master with run-time selectable mode, bit order and chip select.
// Everything runs on clk; sclk is a registered data output, never a clock.
module spi_master_cfg #(
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned CLK_DIV = 11,
    parameter int unsigned NUM_CS  = 2,
    localparam int unsigned CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_CS-1:0] cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dout
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam int unsigned TOG_W = $clog2(2 * DATA_W + 1);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t            state;
    logic [CNT_W-1:0]  div_cnt;
    logic [TOG_W-1:0]  tog_cnt;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic              cpha_q;
    logic              lsb_q;
    logic              cs_ok_q;
    logic              tick;
    logic              last_tog;
    logic              cs_ok;

    assign tick     = (div_cnt == CNT_W'(CLK_DIV - 1));
    assign last_tog = (tog_cnt == TOG_W'(2 * DATA_W - 1));
    assign cs_ok    = (32'(cs_sel) < NUM_CS);

    function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? {1'b0, v[DATA_W-1:1]} : {v[DATA_W-2:0], 1'b0};
    endfunction

    // Frame sequencer; sample and shift alternate on even/odd sclk toggles,
    // with cpha choosing which of the two phases samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div_cnt <= '0;
            tog_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            cs_ok_q <= 1'b0;
            sclk    <= cpol;
            mosi    <= 1'b0;
            cs_n    <= '1;
            busy    <= 1'b0;
            done    <= 1'b0;
            dout    <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE) begin
                div_cnt <= tick ? '0 : div_cnt + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LEAD;
                        busy    <= 1'b1;
                        div_cnt <= '0;
                        tog_cnt <= '0;
                        rx_sr   <= '0;
                        cpha_q  <= cpha;
                        lsb_q   <= lsb_first;
                        cs_ok_q <= cs_ok;
                        sclk    <= cpol;
                        cs_n    <= cs_ok ? ~(NUM_CS'(1) << cs_sel) : '1;
                        if (cpha) begin
                            tx_sr <= din;
                            mosi  <= 1'b0;
                        end else begin
                            tx_sr <= shift_out(din, lsb_first);
                            mosi  <= cs_ok & first_bit(din, lsb_first);
                        end
                    end
                end
                LEAD: begin
                    if (tick) begin
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (tick) begin
                        sclk    <= ~sclk;
                        tog_cnt <= tog_cnt + TOG_W'(1);
                        if (tog_cnt[0] == cpha_q) begin
                            rx_sr <= lsb_q ? {miso, rx_sr[DATA_W-1:1]}
                                           : {rx_sr[DATA_W-2:0], miso};
                        end else begin
                            mosi  <= cs_ok_q & first_bit(tx_sr, lsb_q);
                            tx_sr <= shift_out(tx_sr, lsb_q);
                        end
                        if (last_tog) begin
                            state <= TRAIL;
                        end
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        state   <= IDLE;
                        tog_cnt <= '0;
                        cs_n    <= '1;
                        mosi    <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        dout    <= rx_sr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Directed bench for spi_master_cfg: vector table on the default build, plus
// hand sequences for mid-frame reset and two alternate parameterisations.
module tb_spi_master_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, cpol, cpha, lsb_first, miso, cs_sel, v_loop;
    logic [11:0] din, dout;
    logic        sclk, mosi, busy, done;
    logic [1:0]  cs_n;

    logic        start_x, cpol_x, cpha_x, lsb_x;
    logic [1:0]  sel_x;
    logic [7:0]  din_x, dout1;
    logic        sclk1, mosi1, busy1, done1;
    logic [3:0]  cs_n1;
    logic [3:0]  dout2;
    logic        sclk2, mosi2, busy2, done2;
    logic [2:0]  cs_n2;

    spi_master_cfg u0 (
        .clk(clk), .rst(rst), .start(start), .din(din), .cs_sel(cs_sel),
        .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .miso(miso),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy), .done(done), .dout(dout)
    );

    spi_master_cfg #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(4)) u1 (
        .clk(clk), .rst(rst), .start(start_x), .din(din_x), .cs_sel(sel_x),
        .cpol(cpol_x), .cpha(cpha_x), .lsb_first(lsb_x), .miso(mosi1),
        .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1), .busy(busy1), .done(done1), .dout(dout1)
    );

    spi_master_cfg #(.DATA_W(4), .CLK_DIV(3), .NUM_CS(3)) u2 (
        .clk(clk), .rst(rst), .start(start_x), .din(din_x[3:0]), .cs_sel(sel_x),
        .cpol(cpol_x), .cpha(cpha_x), .lsb_first(lsb_x), .miso(mosi2),
        .sclk(sclk2), .mosi(mosi2), .cs_n(cs_n2), .busy(busy2), .done(done2), .dout(dout2)
    );

    typedef struct {
        logic        cpol, cpha, lsb, sel;
        logic [11:0] din, sword;
        logic        loop;
        logic [11:0] edout, esrx;
        logic        efirst;
        logic [1:0]  ecs;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // slave model and bus monitors
    logic        s_act = 1'b0, s_prev = 1'b0, s_miso = 1'b0, s_first = 1'b0;
    logic        s_cpol, s_cpha, s_lsb;
    logic [11:0] s_word, s_tx, s_rx;
    int          s_cnt = 0;
    logic [1:0]  mon_exp = 2'b11;
    logic [3:0]  mexp1 = 4'hF;
    logic [2:0]  mexp2 = 3'b111;
    int          mon_bad = 0, mon1 = 0, mon2 = 0, idle_mosi = 0;

    assign miso = v_loop ? mosi : s_miso;

    task automatic s_present();
        s_miso = s_lsb ? s_tx[0] : s_tx[11];
        s_tx   = s_lsb ? (s_tx >> 1) : (s_tx << 1);
    endtask

    task automatic s_sample();
        if (s_cnt == 0) s_first = mosi;
        s_rx  = s_lsb ? {mosi, s_rx[11:1]} : {s_rx[10:0], mosi};
        s_cnt = s_cnt + 1;
    endtask

    always @(negedge clk) begin
        if (cs_n === 2'b11 || $isunknown(cs_n)) begin
            s_act = 1'b0;
        end else if (!s_act) begin
            s_act  = 1'b1;
            s_prev = sclk;
            s_cnt  = 0;
            s_rx   = '0;
            s_tx   = s_word;
            if (!s_cpha) s_present();
        end else if (sclk !== s_prev) begin
            s_prev = sclk;
            if (sclk != s_cpol) begin
                if (!s_cpha) s_sample(); else s_present();
            end else begin
                if (!s_cpha) s_present(); else s_sample();
            end
        end
        if (busy === 1'b1 && (cs_n !== mon_exp)) mon_bad++;
        if (busy1 === 1'b1 && (cs_n1 !== mexp1)) mon1++;
        if (busy2 === 1'b1 && (cs_n2 !== mexp2 || (mexp2 == 3'b111 && mosi2 !== 1'b0))) mon2++;
        if (cs_n === 2'b11 && mosi !== 1'b0) idle_mosi++;
        if (cs_n1 === 4'hF && mosi1 !== 1'b0) idle_mosi++;
        if (cs_n2 === 3'b111 && mosi2 !== 1'b0) idle_mosi++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One frame on u0; a start with scrambled config is injected mid-frame.
    task automatic run_vec(input vec_t v, input int idx);
        int  cyc;
        logic got;
        cpol = v.cpol; cpha = v.cpha; lsb_first = v.lsb; cs_sel = v.sel; din = v.din;
        v_loop = v.loop; s_cpol = v.cpol; s_cpha = v.cpha; s_lsb = v.lsb; s_word = v.sword;
        mon_exp = v.ecs; mon_bad = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 40) begin
                start = 1'b1; din = ~din; cpol = ~cpol; cpha = ~cpha;
                lsb_first = ~lsb_first; cs_sel = ~cs_sel;
            end else if (cyc == 41) begin
                start = 1'b0;
            end
            if (done === 1'b1) got = 1'b1;
        end
        chk($sformatf("v%0d cycles", idx), cyc, 286);
        chk($sformatf("v%0d dout", idx), dout, v.edout);
        chk($sformatf("v%0d slave_rx", idx), s_rx, v.esrx);
        chk($sformatf("v%0d slave_bits", idx), s_cnt, 12);
        chk($sformatf("v%0d first_bit", idx), s_first, v.efirst);
        chk($sformatf("v%0d cs_n_during", idx), mon_bad, 0);
        chk($sformatf("v%0d cs_n_at_done", idx), cs_n, 2'b11);
        chk($sformatf("v%0d busy_at_done", idx), busy, 0);
    endtask

    // Simultaneous frame on u1 and u2 (loopback on both).
    task automatic run_x(input logic [7:0] d, input logic pol, input logic pha, input logic lsb,
                         input logic [1:0] sel, input logic [3:0] e1cs, input logic [2:0] e2cs,
                         input logic [7:0] e1d, input logic [3:0] e2d, input string nm);
        int c1, c2;
        din_x = d; cpol_x = pol; cpha_x = pha; lsb_x = lsb; sel_x = sel;
        mexp1 = e1cs; mexp2 = e2cs; mon1 = 0; mon2 = 0;
        start_x = 1'b1;
        @(posedge clk); #1;
        start_x = 1'b0;
        c1 = 0; c2 = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (done1 === 1'b1 && c1 == 0) c1 = c;
            if (done2 === 1'b1 && c2 == 0) c2 = c;
        end
        chk({nm, " u1 cycles"}, c1, 36);
        chk({nm, " u2 cycles"}, c2, 30);
        chk({nm, " u1 dout"}, dout1, e1d);
        chk({nm, " u2 dout"}, dout2, e2d);
        chk({nm, " u1 cs_n"}, mon1, 0);
        chk({nm, " u2 cs_n/mosi"}, mon2, 0);
    endtask

    vec_t vecs[8];

    initial begin
        int dcount;
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'hA5C, 12'h000, 1'b1, 12'hA5C, 12'hA5C, 1'b1, 2'b10};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h7E2, 12'h3C1, 1'b0, 12'h3C1, 12'h7E2, 1'b0, 2'b10};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h7E2, 12'h3C1, 1'b0, 12'h3C1, 12'h7E2, 1'b0, 2'b10};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h7E2, 12'h3C1, 1'b0, 12'h3C1, 12'h7E2, 1'b0, 2'b10};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h7E2, 12'h3C1, 1'b0, 12'h3C1, 12'h7E2, 1'b0, 2'b10};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h001, 12'h000, 1'b1, 12'h001, 12'h001, 1'b1, 2'b01};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 12'h7E2, 12'h3C1, 1'b0, 12'h3C1, 12'h7E2, 1'b0, 2'b01};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 12'h000, 1'b1, 12'h123, 12'h123, 1'b0, 2'b10};

        // reset, with start held high to confirm reset wins
        rst = 1'b1; start = 1'b1; cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0;
        cs_sel = 1'b0; din = 12'hFFF; v_loop = 1'b1;
        s_cpol = 1'b0; s_cpha = 1'b0; s_lsb = 1'b0; s_word = '0; s_tx = '0; s_rx = '0;
        start_x = 1'b0; cpol_x = 1'b0; cpha_x = 1'b0; lsb_x = 1'b0; sel_x = '0; din_x = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst sclk", sclk, 1);
        chk("rst mosi", mosi, 0);
        chk("rst cs_n", cs_n, 2'b11);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst dout", dout, 0);
        chk("rst u1 cs_n", cs_n1, 4'hF);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("no start after rst", busy, 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // reset at the seventh XFER tick (edge 8*CLK_DIV after acceptance)
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; cs_sel = 1'b0; din = 12'hA5C;
        v_loop = 1'b1; mon_exp = 2'b10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (87) @(posedge clk);
        #1;
        chk("mid busy before rst", busy, 1);
        chk("mid dout before rst", dout, 12'h123);
        cpol = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        chk("mid rst cs_n", cs_n, 2'b11);
        chk("mid rst busy", busy, 0);
        chk("mid rst dout", dout, 0);
        chk("mid rst mosi", mosi, 0);
        chk("mid rst sclk", sclk, 1);
        rst = 1'b0;
        dcount = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dcount++;
        end
        chk("mid rst done pulses", dcount, 0);
        chk("mid rst busy after", busy, 0);

        run_x(8'h3A, 1'b1, 1'b1, 1'b1, 2'd2, 4'b1011, 3'b011, 8'h3A, 4'hA, "x0");
        run_x(8'h96, 1'b0, 1'b0, 1'b0, 2'd3, 4'b0111, 3'b111, 8'h96, 4'h0, "x1");

        chk("mosi while deselected", idle_mosi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
